// File: rtl/dtree_seq_ctrl.sv
// dtree_seq_ctrl: sequential decision-tree classifier. One shared threshold
// comparator walks one node of a runtime-loadable table per cycle.
// Optional build macro: DTREE_SEQ_STEPCNT_EN adds out_steps, the number of
// internal nodes traversed for the presented result.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid and its data stable until that edge.
module dtree_seq_ctrl #(
  parameter int NUM_FEAT  = 6,
  parameter int FEAT_W    = 8,
  parameter int NODES     = 32,
  parameter int ADDR_W    = 5,
  parameter int CLASS_W   = 2,
  parameter int MAX_DEPTH = 15,
  localparam int NODE_W   = 1 + 3 + 3 + FEAT_W + 2 * ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_FEAT*FEAT_W-1:0] in_feat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CLASS_W-1:0]         out_class,
  output logic                       out_err,
  input  logic                       cfg_we,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic [NODE_W-1:0]          cfg_data,
  output logic                       cfg_err,
`ifdef DTREE_SEQ_STEPCNT_EN
  output logic [3:0]                 out_steps,
`endif
  output logic [1:0]                 dbg_state_o
);

  localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1);
  localparam int FEAT_LSB = NODE_W - 4;
  localparam int PREC_LSB = NODE_W - 7;
  localparam int THR_LSB  = 2 * ADDR_W;
  localparam logic [NODE_W-1:0] LEAF0 = {1'b1, {(NODE_W-1){1'b0}}};

  // One bit per encodable address: set where the address lies inside the table.
  function automatic logic [2**ADDR_W-1:0] mk_addr_ok();
    logic [2**ADDR_W-1:0] m;
    m = '0;
    for (int i = 0; i < 2**ADDR_W; i++) m[i] = (i < NODES);
    return m;
  endfunction
  localparam logic [2**ADDR_W-1:0] ADDR_OK = mk_addr_ok();

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EVAL = 2'd1, S_DONE = 2'd2} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           ptr_q, ptr_d;
  logic [DEPTH_W-1:0]          depth_q, depth_d;
  logic [NUM_FEAT*FEAT_W-1:0]  feat_q, feat_d;
  logic [CLASS_W-1:0]          cls_q, cls_d;
  logic                        err_q, err_d;
  logic                        cfg_err_q, cfg_err_d;
  logic [NODE_W-1:0]           tbl_q [NODES];
  logic [NODE_W-1:0]           node_w;
  logic                        tbl_we;
  logic [FEAT_W-1:0]           feat_sel, key;
  logic                        go_left;
  int                          shamt;
`ifdef DTREE_SEQ_STEPCNT_EN
  logic [3:0]                  steps_q, steps_d;
`endif

  wire                n_leaf    = node_w[NODE_W-1];
  wire [2:0]          n_feat    = node_w[FEAT_LSB +: 3];
  wire [2:0]          n_prec_m1 = node_w[PREC_LSB +: 3];
  wire [FEAT_W-1:0]   n_thr     = node_w[THR_LSB +: FEAT_W];
  wire [ADDR_W-1:0]   n_left    = node_w[ADDR_W +: ADDR_W];
  wire [ADDR_W-1:0]   n_right   = node_w[0 +: ADDR_W];

  // Table writes land only in IDLE and only inside the table; anything else is flagged.
  always_comb begin
    tbl_we    = cfg_we && (state_q == S_IDLE) && ADDR_OK[cfg_addr];
    cfg_err_d = cfg_we && !tbl_we;
  end

  // Node table; reset leaves every entry as a class-0 leaf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) tbl_q[i] <= LEAF0;
    end else if (tbl_we) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  // Current node; a pointer past the table end reads as a class-0 leaf.
  always_comb begin
    node_w = LEAF0;
    if (ADDR_OK[ptr_q]) node_w = tbl_q[ptr_q];
  end

  // Shared comparator: selected feature truncated to its prec MSBs against thr.
  always_comb begin
    feat_sel = feat_q[FEAT_W-1:0];
    for (int i = 1; i < NUM_FEAT; i++) begin
      if (int'(n_feat) == i) feat_sel = feat_q[i*FEAT_W +: FEAT_W];
    end
    shamt = FEAT_W - (int'(n_prec_m1) + 1);
    if (shamt < 0) shamt = 0;
    key     = feat_sel >> shamt;
    go_left = (key <= n_thr);
  end

  // Next-state and datapath updates for IDLE -> EVAL -> DONE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    feat_d  = feat_q;
    cls_d   = cls_q;
    err_d   = err_q;
`ifdef DTREE_SEQ_STEPCNT_EN
    steps_d = steps_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          feat_d  = in_feat;
          ptr_d   = '0;
          depth_d = '0;
`ifdef DTREE_SEQ_STEPCNT_EN
          steps_d = '0;
`endif
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (n_leaf) begin
          cls_d   = n_thr[CLASS_W-1:0];
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
          cls_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          ptr_d   = go_left ? n_left : n_right;
          depth_d = depth_q + DEPTH_W'(1);
`ifdef DTREE_SEQ_STEPCNT_EN
          if (steps_q != 4'hF) steps_d = steps_q + 4'd1;
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      depth_q   <= '0;
      feat_q    <= '0;
      cls_q     <= '0;
      err_q     <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef DTREE_SEQ_STEPCNT_EN
      steps_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      depth_q   <= depth_d;
      feat_q    <= feat_d;
      cls_q     <= cls_d;
      err_q     <= err_d;
      cfg_err_q <= cfg_err_d;
`ifdef DTREE_SEQ_STEPCNT_EN
      steps_q   <= steps_d;
`endif
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign out_class   = cls_q;
  assign out_err     = err_q;
  assign cfg_err     = cfg_err_q;
  assign dbg_state_o = state_q;
`ifdef DTREE_SEQ_STEPCNT_EN
  assign out_steps   = steps_q;
`endif

endmodule

// File: tb/tb_dtree_seq_ctrl.sv
// Bench for dtree_seq_ctrl: random and directed vectors against a table-walk
// reference model; results are queued at issue and popped by a monitor.
`timescale 1ns/1ps
module tb_dtree_seq_ctrl;

  localparam int NUM_FEAT  = 6;
  localparam int FEAT_W    = 8;
  localparam int NODES     = 24;
  localparam int ADDR_W    = 5;
  localparam int CLASS_W   = 2;
  localparam int MAX_DEPTH = 15;
  localparam int NODE_W    = 25;
  localparam int EXP_W     = 40;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [NUM_FEAT*FEAT_W-1:0] in_feat = '0;
  logic                       out_valid;
  logic                       out_ready = 1'b1;
  logic [CLASS_W-1:0]         out_class;
  logic                       out_err;
  logic                       cfg_we = 1'b0;
  logic [ADDR_W-1:0]          cfg_addr = '0;
  logic [NODE_W-1:0]          cfg_data = '0;
  logic                       cfg_err;
  logic [1:0]                 dbg_state;
`ifdef DTREE_SEQ_STEPCNT_EN
  logic [3:0]                 out_steps;
`endif

  dtree_seq_ctrl #(.NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W), .NODES(NODES),
                   .ADDR_W(ADDR_W), .CLASS_W(CLASS_W), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
`ifdef DTREE_SEQ_STEPCNT_EN
    .out_steps(out_steps),
`endif
    .dbg_state_o(dbg_state)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [NODE_W-1:0] mtbl [NODES];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model
  function automatic logic [NODE_W-1:0] mk_int(int f, int pm1, int thr, int l, int r);
    return {1'b0, 3'(f), 3'(pm1), 8'(thr), 5'(l), 5'(r)};
  endfunction

  function automatic logic [NODE_W-1:0] mk_leaf(int c);
    return {1'b1, 3'd0, 3'd0, 8'(c), 10'd0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NODES; i++) mtbl[i] = mk_leaf(0);
  endtask

  function automatic void model(input logic [47:0] x, output logic [1:0] c,
                                output logic e, output int d);
    int p, f, fv, prec, key, thr;
    logic [NODE_W-1:0] w;
    p = 0; d = 0; c = 2'd0; e = 1'b0;
    for (int s = 0; s <= MAX_DEPTH + 1; s++) begin
      if (p >= NODES) return;
      w = mtbl[p];
      if (w[24]) begin c = w[11:10]; return; end
      if (d == MAX_DEPTH) begin e = 1'b1; return; end
      f = int'(w[23:21]);
      if (f >= NUM_FEAT) f = 0;
      fv   = int'((x >> (8 * f)) & 48'hFF);
      prec = int'(w[20:18]) + 1;
      key  = fv / (1 << (8 - prec));
      thr  = int'(w[17:10]);
      p = (key <= thr) ? int'(w[9:5]) : int'(w[4:0]);
      d++;
    end
  endfunction

  function automatic logic [47:0] rand_vec();
    return {16'($urandom_range(0, 65535)), 32'($urandom)};
  endfunction

  // Driver tasks
  task automatic wait_idle();
    int budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 300) begin @(negedge clk); budget++; end
    if (!in_ready) check("idle_timeout", in_ready, 1);
  endtask

  task automatic drive(input logic [47:0] x, input bit do_cfg,
                       input logic [4:0] a, input logic [NODE_W-1:0] w);
    logic [1:0] c; logic e; int d; int k; int budget;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 300) begin @(negedge clk); budget++; end
    if (!in_ready) begin check("in_ready_timeout", in_ready, 1); return; end
    in_valid = 1'b1;
    in_feat  = x;
    if (do_cfg) begin
      cfg_we = 1'b1; cfg_addr = a; cfg_data = w;
      if (a < NODES) mtbl[a] = w;
    end
    model(x, c, e, d);
    k = cyc + 1;
    exp_q.push_back({32'(k + d + 2), e, c, 5'(d)});
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [NODE_W-1:0] w, input bit busy);
    bit rej;
    rej = busy || (a >= NODES);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = w;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_pulse", cfg_err, rej);
    if (!rej) mtbl[a] = w;
    @(negedge clk);
    check("cfg_err_clear", cfg_err, 0);
  endtask

  // Scoreboard monitor
  logic       prev_valid = 1'b0;
  logic [1:0] hold_c;
  logic       hold_e;
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("class", out_class, e[6:5]);
          check("err", out_err, e[7]);
          check("latency_edge", cyc + 1, e[39:8]);
`ifdef DTREE_SEQ_STEPCNT_EN
          check("steps", out_steps, e[4:0]);
`endif
          hold_c = e[6:5];
          hold_e = e[7];
        end
      end else if (out_valid) begin
        check("hold_class", out_class, hold_c);
        check("hold_err", out_err, hold_e);
        check("in_ready_in_done", in_ready, 0);
      end
      prev_valid = out_valid;
    end
  end

  // Main sequence
  initial begin
    logic [47:0] x;
    logic [7:0]  sv [4];
    int budget;
    sv[0] = 8'h00; sv[1] = 8'h40; sv[2] = 8'h80; sv[3] = 8'hC0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_err", out_err, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;

    // Cleared table: every vector lands on a class-0 leaf immediately
    drive(rand_vec(), 0, 0, '0);

    // Single split on X5 with 4-bit precision
    wait_idle();
    cfg_write(5'd0, mk_int(5, 3, 1, 1, 2), 0);
    cfg_write(5'd1, mk_leaf(1), 0);
    cfg_write(5'd2, mk_leaf(3), 0);
    x = rand_vec(); x[40 +: 8] = 8'h1F; drive(x, 0, 0, '0);
    x = rand_vec(); x[40 +: 8] = 8'h20; drive(x, 0, 0, '0);
    for (int i = 0; i < 4; i++) drive(rand_vec(), 0, 0, '0);

    // Two-level tree on X3 / X4, each at 2-bit precision
    wait_idle();
    cfg_write(5'd0, mk_int(3, 1, 1, 1, 2), 0);
    cfg_write(5'd1, mk_int(4, 1, 0, 3, 4), 0);
    cfg_write(5'd2, mk_int(4, 1, 2, 5, 6), 0);
    for (int i = 0; i < 4; i++) cfg_write(5'(3 + i), mk_leaf(i), 0);
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        x = rand_vec(); x[24 +: 8] = sv[a]; x[32 +: 8] = sv[b];
        drive(x, 0, 0, '0);
      end
    end
    // Write and accept in the same cycle: evaluation must see the new leaf
    x = rand_vec(); x[24 +: 8] = 8'h00; x[32 +: 8] = 8'h00;
    drive(x, 1, 5'd3, mk_leaf(2));

    // Child pointer past the table end reads as a class-0 leaf
    wait_idle();
    cfg_write(5'd0, mk_int(0, 7, 255, 30, 30), 0);
    drive(rand_vec(), 0, 0, '0);

    // Self-loop: depth abort, write rejected mid-evaluation
    wait_idle();
    cfg_write(5'd0, mk_int(0, 0, 0, 0, 0), 0);
    drive(rand_vec(), 0, 0, '0);
    cfg_write(5'd0, mk_leaf(2), 1);
    drive(rand_vec(), 0, 0, '0);
    wait_idle();
    cfg_write(5'd28, mk_leaf(1), 0);
    cfg_write(5'd23, mk_leaf(1), 0);

    // Consumer stall in DONE
    wait_idle();
    cfg_write(5'd0, mk_leaf(2), 0);
    out_ready = 1'b0;
    drive(rand_vec(), 0, 0, '0);
    budget = 0;
    while (!out_valid && budget < 50) begin @(negedge clk); budget++; end
    check("stall_valid_seen", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;

    // Random tables and vectors
    for (int r = 0; r < 3; r++) begin
      wait_idle();
      for (int i = 0; i < NODES; i++) begin
        if ($urandom_range(0, 2) == 0)
          cfg_write(5'(i), mk_leaf($urandom_range(0, 3)), 0);
        else
          cfg_write(5'(i), mk_int($urandom_range(0, 7), $urandom_range(0, 7),
                                  $urandom_range(0, 255), $urandom_range(0, 25),
                                  $urandom_range(0, 25)), 0);
      end
      cfg_write(5'($urandom_range(NODES, 31)), mk_leaf(3), 0);
      for (int j = 0; j < 10; j++) drive(rand_vec(), 0, 0, '0);
    end

    // Reset mid-evaluation drops the result and clears the table
    wait_idle();
    cfg_write(5'd0, mk_int(0, 0, 0, 0, 0), 0);
    drive(rand_vec(), 0, 0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(rand_vec(), 0, 0, '0);
    drive(rand_vec(), 0, 0, '0);

    budget = 0;
    while (exp_q.size() != 0 && budget < 300) begin @(negedge clk); budget++; end
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
